// File: rtl/quad_phase_pkg.sv
// Shared quadrant encoding and step/decode helpers for the quadrant phase controller.
package quad_phase_pkg;

    localparam logic [1:0] QA = 2'd0;
    localparam logic [1:0] QB = 2'd1;
    localparam logic [1:0] QC = 2'd2;
    localparam logic [1:0] QD = 2'd3;

    typedef enum logic [1:0] {
        QuadA = QA,
        QuadB = QB,
        QuadC = QC,
        QuadD = QD
    } quad_e;

    // {sign_bit, phase_pos} for each quadrant.
    function automatic logic [1:0] quad_decode(input quad_e q);
        case (q)
            QuadA:   return 2'b00;
            QuadB:   return 2'b01;
            QuadC:   return 2'b10;
            QuadD:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic quad_e quad_fwd(input quad_e q);
        case (q)
            QuadA:   return QuadB;
            QuadB:   return QuadC;
            QuadC:   return QuadD;
            QuadD:   return QuadA;
            default: return QuadA;
        endcase
    endfunction

    function automatic quad_e quad_rev(input quad_e q);
        case (q)
            QuadA:   return QuadD;
            QuadB:   return QuadA;
            QuadC:   return QuadB;
            QuadD:   return QuadC;
            default: return QuadA;
        endcase
    endfunction

endpackage

// File: rtl/phase_accum.sv
// Phase accumulator: adds or subtracts the tuning word each enabled cycle and
// flags the carry (forward) or borrow (reverse) produced by that update.
module phase_accum #(
    parameter int unsigned ACC_W = 16
) (
    input  logic             clk_star,
    input  logic             reset,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             dir,
    input  logic [ACC_W-1:0] ftw,
    output logic [ACC_W-1:0] acc,
    output logic             step
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W:0]   acc_d;

    // The extra top bit is the carry on add and the borrow on subtract.
    always_comb begin
        acc_d = '0;
        if (dir) begin
            acc_d = {1'b0, acc_q} - {1'b0, ftw};
        end else begin
            acc_d = {1'b0, acc_q} + {1'b0, ftw};
        end
    end

    assign step = en & acc_d[ACC_W];
    assign acc  = acc_q;

    always_ff @(posedge clk_star) begin
        if (reset || sync_clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_d[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/quad_phase_ctrl.sv
// Quadrant phase controller: accumulator-driven quadrant FSM producing sign/mirror
// controls, the mirrored quarter-wave ROM address and a once-per-period tick.
module quad_phase_ctrl
    import quad_phase_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned FRAC_W = 8
) (
    input  logic                     clk_star,
    input  logic                     reset,
    input  logic                     en,
    input  logic [ADDR_W+FRAC_W-1:0] ftw,
    input  logic                     dir,
    input  logic                     sync_clr,
    output logic                     sign_bit,
    output logic                     phase_pos,
    output logic [1:0]               quad,
    output logic [ADDR_W-1:0]        rom_addr,
    output logic                     period_tick
);

    localparam int unsigned ACC_W = ADDR_W + FRAC_W;

    logic [ACC_W-1:0] acc;
    logic             step;
    quad_e            pstate_q;
    logic             tick_q;

    phase_accum #(
        .ACC_W(ACC_W)
    ) u_phase_accum (
        .clk_star(clk_star),
        .reset   (reset),
        .en      (en),
        .sync_clr(sync_clr),
        .dir     (dir),
        .ftw     (ftw),
        .acc     (acc),
        .step    (step)
    );

    // Clearing on the same edge as a wrapping step swallows that step's tick.
    always_ff @(posedge clk_star) begin
        if (reset || sync_clr) begin
            pstate_q <= QuadA;
            tick_q   <= 1'b0;
        end else if (step) begin
            if (dir) begin
                pstate_q <= quad_rev(pstate_q);
                tick_q   <= (pstate_q == QuadA);
            end else begin
                pstate_q <= quad_fwd(pstate_q);
                tick_q   <= (pstate_q == QuadD);
            end
        end else begin
            tick_q <= 1'b0;
        end
    end

    assign {sign_bit, phase_pos} = quad_decode(pstate_q);
    assign quad                  = pstate_q;
    assign period_tick           = tick_q;
    assign rom_addr              = acc[ACC_W-1 -: ADDR_W] ^ {ADDR_W{phase_pos}};

endmodule

// File: tb/tb_quad_phase_ctrl.sv
// Bench for quad_phase_ctrl: directed scenarios with literal expectations plus
// randomized traffic against a whole-period phase model.
module tb_quad_phase_ctrl;

    localparam int ADDR_W = 4;
    localparam int FRAC_W = 4;
    localparam int ACC_W  = ADDR_W + FRAC_W;
    localparam int PERIOD = 4 * (1 << ACC_W);

    logic             clk_star = 1'b0;
    logic             reset    = 1'b0;
    logic             en       = 1'b0;
    logic [ACC_W-1:0] ftw      = '0;
    logic             dir      = 1'b0;
    logic             sync_clr = 1'b0;
    logic             sign_bit;
    logic             phase_pos;
    logic [1:0]       quad;
    logic [ADDR_W-1:0] rom_addr;
    logic             period_tick;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_on  = 1'b0;

    // Model: position within the full 4-quadrant period, plus the pending tick.
    int m_p    = 0;
    int m_tick = 0;

    logic [3:0] fwd_rom [16] = '{4'h4, 4'h8, 4'hC, 4'hF, 4'hB, 4'h7, 4'h3, 4'h0,
                                 4'h4, 4'h8, 4'hC, 4'hF, 4'hB, 4'h7, 4'h3, 4'h0};

    quad_phase_ctrl #(
        .ADDR_W(ADDR_W),
        .FRAC_W(FRAC_W)
    ) dut (
        .clk_star   (clk_star),
        .reset      (reset),
        .en         (en),
        .ftw        (ftw),
        .dir        (dir),
        .sync_clr   (sync_clr),
        .sign_bit   (sign_bit),
        .phase_pos  (phase_pos),
        .quad       (quad),
        .rom_addr   (rom_addr),
        .period_tick(period_tick)
    );

    always #5 clk_star = ~clk_star;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_star) begin
        int s;
        if (reset || sync_clr) begin
            m_p    = 0;
            m_tick = 0;
        end else if (en) begin
            if (!dir) begin
                s      = m_p + int'(ftw);
                m_tick = (s >= PERIOD) ? 1 : 0;
                m_p    = s % PERIOD;
            end else begin
                s      = m_p - int'(ftw);
                m_tick = (s < 0) ? 1 : 0;
                m_p    = (s + PERIOD) % PERIOD;
            end
        end else begin
            m_tick = 0;
        end
    end

    always @(negedge clk_star) begin
        int mq, mhi, mrom;
        if (chk_on) begin
            mq   = m_p / (1 << ACC_W);
            mhi  = (m_p % (1 << ACC_W)) / (1 << FRAC_W);
            mrom = (mq % 2 == 1) ? ((1 << ADDR_W) - 1 - mhi) : mhi;
            check("m_quad", int'(quad), mq);
            check("m_sign", int'(sign_bit), mq / 2);
            check("m_phase_pos", int'(phase_pos), mq % 2);
            check("m_rom_addr", int'(rom_addr), mrom);
            check("m_tick", int'(period_tick), m_tick);
        end
    end

    task automatic drive(input logic r, input logic e, input logic d, input logic c,
                         input logic [ACC_W-1:0] f);
        reset    = r;
        en       = e;
        dir      = d;
        sync_clr = c;
        ftw      = f;
        @(posedge clk_star);
        @(negedge clk_star);
        #1;
    endtask

    initial begin
        @(negedge clk_star);
        #1;
        chk_on = 1'b1;

        repeat (3) begin
            drive(1, 1, 0, 0, 8'h40);
            check("reset_quad", int'(quad), 0);
            check("reset_rom", int'(rom_addr), 0);
            check("reset_tick", int'(period_tick), 0);
        end

        for (int k = 1; k <= 16; k++) begin
            drive(0, 1, 0, 0, 8'h40);
            check("fwd_rom", int'(rom_addr), int'(fwd_rom[k-1]));
            check("fwd_quad", int'(quad), (k / 4) % 4);
            check("fwd_tick", int'(period_tick), (k == 16) ? 1 : 0);
        end

        drive(0, 1, 0, 0, 8'h40);
        drive(0, 1, 0, 0, 8'h40);
        repeat (5) begin
            drive(0, 0, 0, 0, 8'h40);
            check("hold_en_rom", int'(rom_addr), 8);
            check("hold_en_tick", int'(period_tick), 0);
        end
        repeat (5) begin
            drive(0, 1, 0, 0, 8'h00);
            check("hold_ftw0_rom", int'(rom_addr), 8);
            check("hold_ftw0_quad", int'(quad), 0);
        end

        drive(0, 0, 0, 1, 8'h40);
        for (int k = 1; k <= 16; k++) begin
            drive(0, 1, 1, 0, 8'h40);
            check("rev_quad", int'(quad), 3 - (k - 1) / 4);
            check("rev_tick", int'(period_tick), (k == 1) ? 1 : 0);
            if (k == 1) check("rev_rom_first", int'(rom_addr), 3);
        end

        drive(0, 0, 0, 1, 8'h40);
        repeat (8) drive(0, 1, 0, 0, 8'h40);
        check("in_c_quad", int'(quad), 2);
        drive(0, 1, 0, 1, 8'h40);
        check("clr_en_quad", int'(quad), 0);
        check("clr_en_rom", int'(rom_addr), 0);
        check("clr_en_tick", int'(period_tick), 0);

        repeat (15) drive(0, 1, 0, 0, 8'h40);
        drive(0, 1, 0, 1, 8'h40);
        check("clr_wrap_tick", int'(period_tick), 0);

        repeat (15) drive(0, 1, 0, 0, 8'h40);
        drive(1, 1, 0, 0, 8'h40);
        check("rst_wrap_tick", int'(period_tick), 0);
        check("rst_wrap_quad", int'(quad), 0);

        drive(0, 0, 0, 1, 8'h40);
        repeat (7) drive(0, 1, 0, 0, 8'h40);
        check("flip_pre_quad", int'(quad), 1);
        check("flip_pre_rom", int'(rom_addr), 3);
        drive(0, 1, 1, 0, 8'h40);
        check("flip_quad", int'(quad), 1);
        check("flip_rom", int'(rom_addr), 7);
        check("flip_tick", int'(period_tick), 0);

        for (int i = 0; i < 3000; i++) begin
            logic [ACC_W-1:0] f;
            case ($urandom_range(0, 3))
                0:       f = '0;
                1:       f = ACC_W'($urandom_range(248, 255));
                default: f = ACC_W'($urandom_range(0, 255));
            endcase
            drive(logic'($urandom_range(0, 99) == 0), logic'($urandom_range(0, 9) < 8),
                  logic'($urandom_range(0, 1)), logic'($urandom_range(0, 99) < 3), f);
        end

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
